// File: rtl/shift_reg_tx_if.sv
// Parallel word handshake into the serial transmitter.
interface shift_reg_tx_if #(parameter int SIZE = 8);
  // A word moves when VALID && READY at a rising CLK edge; DATA matters only on that edge.
  logic [SIZE-1:0] DATA;
  logic            VALID;
  logic            READY;

  modport master (output DATA, output VALID, input READY);
  modport slave  (input DATA, input VALID, output READY);
endinterface

// File: rtl/shift_reg_tx.sv
// MSB-first serial word transmitter with a one-word holding buffer, a per-bit
// sample strobe and a frame flag. Bit period is DIV clocks; GAP idle periods follow each word.
module shift_reg_tx #(
  parameter int SIZE = 8,
  parameter int DIV  = 4,
  parameter int GAP  = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  shift_reg_tx_if.slave bus,
  output logic          OUT,
  output logic          EN,
  output logic          FRAME,
  output logic          BUSY,
  output logic [1:0]    dbg_state
);

  localparam int  GAP_LEN = GAP * DIV;
  localparam int  DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int  BIT_W   = $clog2(SIZE);
  localparam int  GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam bit  HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state;
  logic [SIZE-1:0]   shifter;
  logic [SIZE-1:0]   hold;
  logic              hold_full;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic hs, div_last, bit_last, gap_last, word_end, load_direct, to_hold;

  assign bus.READY = !RESET && !hold_full;

  always_comb begin
    hs          = bus.VALID && bus.READY;
    div_last    = (div_cnt == DIV_W'(DIV - 1));
    bit_last    = (bit_cnt == BIT_W'(SIZE - 1));
    gap_last    = (gap_cnt == GAP_W'(GAP_LEN - 1));
    // The edge where the next word may start with no bubble cycle.
    word_end    = (state == S_SHIFT && div_last && bit_last && !HAS_GAP) ||
                  (state == S_GAP && gap_last);
    // A word arriving on that very edge with hold empty goes straight to the shifter.
    load_direct = word_end && !hold_full && hs;
    to_hold     = hs && (state != S_IDLE) && !load_direct;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            shifter <= bus.DATA;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (!bit_last) begin
              shifter <= {shifter[SIZE-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end else if (HAS_GAP) begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end else if (hold_full) begin
              shifter <= hold;
              bit_cnt <= '0;
            end else if (hs) begin
              shifter <= bus.DATA;
              bit_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_last) begin
            gap_cnt <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            if (hold_full) begin
              shifter <= hold;
              state   <= S_SHIFT;
            end else if (hs) begin
              shifter <= bus.DATA;
              state   <= S_SHIFT;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (to_hold) begin
        hold      <= bus.DATA;
        hold_full <= 1'b1;
      end else if (word_end && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Outputs decode registered state only; OUT is forced low outside a frame.
  assign OUT       = (state == S_SHIFT) && shifter[SIZE-1];
  assign EN        = (state == S_SHIFT) && div_last;
  assign FRAME     = (state == S_SHIFT);
  assign BUSY      = (state != S_IDLE) || hold_full;
  assign dbg_state = state;

endmodule

// File: doc/shift_reg_tx.md
# shift_reg_tx

Serial word transmitter: the transmit end of the MSB-first serial link whose receive end is the LSB-shifting register (`{sreg[SIZE-2:0], IN}`) in our components library. It accepts parallel words over a VALID/READY handshake and holds one extra word in a single-entry holding buffer. Each word is shifted out MSB first, one bit per DIV clocks, with a per-bit sample strobe and a frame flag. A receiver on the same CLK that shifts IN on EN reconstructs the word exactly after SIZE strobes.

## Interface
- SIZE, 8: word width in bits, ≥2.
- DIV, 4: clocks per bit period, ≥1.
- GAP, 1: idle bit periods inserted after every word, ≥0.

- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK.
- DATA  in  SIZE  word to send; sampled only on handshake.
- VALID  in  1  DATA valid.
- READY  out  1  word can be accepted; handshake = VALID && READY at a rising edge.
- OUT  out  1  serial data bit.
- EN  out  1  one-cycle strobe; receiver samples OUT on this edge.
- FRAME  out  1  high while a word's bits are on OUT.
- BUSY  out  1  high when not IDLE or holding register full.

## Operation
- Storage:
  - shifter: SIZE bits; OUT = shifter MSB.
  - hold: SIZE bits plus hold_full flag.
  - div_cnt: counts 0..DIV-1.
  - bit_cnt: counts 0..SIZE-1.
  - gap_cnt: counts 0..GAP*DIV-1.
- READY = !RESET && !hold_full (combinational).
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - On handshake: DATA → shifter, → SHIFT. The holding register is bypassed.
- SHIFT:
  - div_cnt increments every cycle.
  - At div_cnt == DIV-1: EN=1 and div_cnt → 0.
    - If bit_cnt < SIZE-1: shifter shifts left (zero-fill) and bit_cnt++.
    - If bit_cnt == SIZE-1 (last bit) and GAP>0: → GAP.
    - If last bit, GAP==0 and hold_full: hold → shifter, hold_full → 0, stay in SHIFT. FRAME stays high.
    - If last bit, GAP==0 and hold empty: → IDLE.
- GAP:
  - OUT=0, EN=0, FRAME=0 for GAP*DIV cycles.
  - On the final cycle: if hold_full, hold → shifter, clear hold_full, → SHIFT; else → IDLE.
- Handshake while in SHIFT or GAP:
  - DATA → hold, hold_full=1.
  - If hold is drained in the same cycle, the new word takes its place and hold_full stays 1.
- Words are sent strictly in acceptance order. No word is dropped or duplicated.
- FRAME=1 exactly in SHIFT. BUSY = (state != IDLE) || hold_full.

## Timing
- Reset values:
  - OUT=0, EN=0, FRAME=0, BUSY=0.
  - READY=0 while RESET is high, 1 on the first cycle after.
  - State IDLE; all counters 0; hold_full=0.
- Latency: handshake in IDLE at edge t → FRAME=1 and OUT=DATA[SIZE-1] in cycle t+1.
- Bit k (k=0 is the MSB) is on OUT in cycles t+1+k·DIV … t+(k+1)·DIV. EN is high in the last of those cycles.
- Word period: (SIZE+GAP)·DIV cycles. With GAP=0 and DIV=1, EN stays continuously high across back-to-back words.
- The holding-register drain and new-word start happen on the same edge; there are no bubble cycles.
- RESET mid-operation aborts the current word, discards hold, and gives reset values on the next cycle. No partial word resumes.
- VALID while READY=0 has no effect. DATA is ignored outside a handshake.

## Test plan
- Reset check: hold RESET 3 cycles with VALID=1 → OUT/EN/FRAME/BUSY/READY all 0 and no word accepted. READY=1 on the first cycle after release.
- Single word, SIZE=8, DIV=4, GAP=1:
  - Stimulus: 0xA5 accepted at edge 0.
  - OUT = 1,0,1,0,0,1,0,1, each bit 4 cycles, from cycle 1.
  - EN pulses at cycles 4,8,…,32.
  - FRAME high in cycles 1–32.
  - Model receiver reads 0xA5; READY stays 1.
- Buffering, same parameters:
  - Stimulus: VALID held with 0x3C, then 0xC3 (second accepted at edge 1).
  - READY low in cycles 2–36.
  - Gap in cycles 33–36 with OUT=0 and FRAME=0.
  - 0xC3 starts at cycle 37; receiver gets 0x3C then 0xC3.
- Streaming, SIZE=8, DIV=1, GAP=0:
  - Stimulus: 0x01, 0x80, 0xFF with VALID always high.
  - 24 consecutive EN cycles with FRAME continuously high.
  - Received words 0x01, 0x80, 0xFF.
- Reset mid-word:
  - Stimulus: RESET at cycle 10 of 0x5A, with 0x99 waiting in hold.
  - Reset values on the next cycle; 0x99 is never emitted.
  - A following 0x77 is transmitted correctly.
- Handshake discipline: VALID pulses with 0xEE while READY=0 → ignored; the output stream is unchanged.
